// File: rtl/rotation_right_shifter_pipe_if.sv
// Handshake bundle for rotation_right_shifter_pipe: input word/amount with valid/ready, result with valid/ready.
// The i_dir signal exists only when ROT_DIR_SEL_EN is defined.
interface rotation_right_shifter_pipe_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  i_num;
    logic [SW-1:0] i_num_bit_rotation;
    logic          o_valid;
    logic          i_ready;
    logic [N-1:0]  o_result;
`ifdef ROT_DIR_SEL_EN
    logic          i_dir;

    modport master (
        output i_valid, i_num, i_num_bit_rotation, i_dir, i_ready,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_valid, i_num, i_num_bit_rotation, i_dir, i_ready,
        output o_ready, o_valid, o_result
    );
`else
    modport master (
        output i_valid, i_num, i_num_bit_rotation, i_ready,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_valid, i_num, i_num_bit_rotation, i_ready,
        output o_ready, o_valid, o_result
    );
`endif
endinterface

// File: rtl/rotation_right_shifter_pipe.sv
// Pipelined barrel rotator: stage k rotates by 2^k when amount bit k is set; latency is $clog2(N) cycles.
// Optional macro ROT_DIR_SEL_EN adds a per-word direction bit (1 = rotate left).
module rotation_right_shifter_pipe #(
    parameter int N = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    rotation_right_shifter_pipe_if.slave bus
);
    localparam int SW = $clog2(N);

    logic          adv;
    logic [N-1:0]  data_reg  [SW];
    logic [N-1:0]  data_in   [SW];
    logic [N-1:0]  data_next [SW];
    logic [SW-1:0] amt_reg   [SW];
    logic [SW-1:0] amt_in    [SW];
    logic          valid_reg [SW];
    logic          valid_in  [SW];
`ifdef ROT_DIR_SEL_EN
    logic          dir_reg   [SW];
    logic          dir_in    [SW];
`endif

    // The whole pipe moves in lockstep; it only stalls when the output word is not being taken.
    assign adv          = !valid_reg[SW-1] || bus.i_ready;
    assign bus.o_ready  = adv;
    assign bus.o_valid  = valid_reg[SW-1];
    assign bus.o_result = data_reg[SW-1];

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic [N-1:0] rot_r;

            if (gi == 0) begin : g_first
                assign data_in[gi]  = bus.i_num;
                assign amt_in[gi]   = bus.i_num_bit_rotation;
                assign valid_in[gi] = bus.i_valid;
`ifdef ROT_DIR_SEL_EN
                assign dir_in[gi]   = bus.i_dir;
`endif
            end else begin : g_chain
                assign data_in[gi]  = data_reg[gi-1];
                assign amt_in[gi]   = amt_reg[gi-1];
                assign valid_in[gi] = valid_reg[gi-1];
`ifdef ROT_DIR_SEL_EN
                assign dir_in[gi]   = dir_reg[gi-1];
`endif
            end

            assign rot_r = (data_in[gi] >> S) | (data_in[gi] << (N - S));

`ifdef ROT_DIR_SEL_EN
            logic [N-1:0] rot_l;
            assign rot_l = (data_in[gi] << S) | (data_in[gi] >> (N - S));
            assign data_next[gi] = !amt_in[gi][gi] ? data_in[gi] :
                                   (dir_in[gi] ? rot_l : rot_r);
`else
            assign data_next[gi] = amt_in[gi][gi] ? rot_r : data_in[gi];
`endif

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    data_reg[gi]  <= '0;
                    amt_reg[gi]   <= '0;
                    valid_reg[gi] <= 1'b0;
`ifdef ROT_DIR_SEL_EN
                    dir_reg[gi]   <= 1'b0;
`endif
                end else if (adv) begin
                    data_reg[gi]  <= data_next[gi];
                    amt_reg[gi]   <= amt_in[gi];
                    valid_reg[gi] <= valid_in[gi];
`ifdef ROT_DIR_SEL_EN
                    dir_reg[gi]   <= dir_in[gi];
`endif
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_rotation_right_shifter_pipe.sv
// Scoreboard bench for rotation_right_shifter_pipe: driver pushes expected words on accept,
// a negedge monitor pops and compares on every output hand-off.
module tb_rotation_right_shifter_pipe;
    localparam int N  = 8;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 clk = ~clk;

    rotation_right_shifter_pipe_if #(.N(N)) bif ();

    rotation_right_shifter_pipe #(.N(N)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bif)
    );

    typedef struct {
        logic [N-1:0] val;
        int           cyc;
        int           stl;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           stalls = 0;
    bit           prev_stall = 1'b0;
    logic [N-1:0] prev_res;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] rot_model(logic [N-1:0] d, int amt, bit left);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = left ? d[(i - amt + N) % N] : d[(i + amt) % N];
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: stall stability, stall back-pressure and ordered result/latency checks.
    always @(negedge clk) begin
        if (i_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bif.o_valid), 32'd1);
                check("hold_result", 32'(bif.o_result), 32'(prev_res));
            end
            if (bif.o_valid && !bif.i_ready)
                check("stall_ready", 32'(bif.o_ready), 32'd0);
            if (bif.o_valid && bif.i_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_output: got %0h, expected no word (cycle %0d)", bif.o_result, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(bif.o_result), 32'(e.val));
                    check("latency", 32'(cyc - e.cyc), 32'(SW + stalls - e.stl));
                end
            end
            prev_stall = bif.o_valid && !bif.i_ready;
            prev_res   = bif.o_result;
            if (prev_stall) stalls++;
        end
    end

    // One clock of stimulus; called #1 after a rising edge, returns #1 after the next one.
    task automatic step(bit v, logic [N-1:0] num, logic [SW-1:0] amt, bit dir, bit rdy, logic [N-1:0] exp);
        bif.i_valid            = v;
        bif.i_num              = v ? num : 'x;
        bif.i_num_bit_rotation = v ? amt : 'x;
        bif.i_ready            = rdy;
`ifdef ROT_DIR_SEL_EN
        bif.i_dir              = dir;
`else
        if (dir) $display("note: direction bit ignored in right-only build");
`endif
        @(negedge clk);
        if (v && bif.o_ready) sb.push_back('{exp, cyc, stalls});
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(bit v, bit rdy);
        logic [N-1:0]  num;
        logic [SW-1:0] amt;
        bit            dir;
        num = N'($urandom);
        amt = SW'($urandom);
`ifdef ROT_DIR_SEL_EN
        dir = 1'($urandom);
`else
        dir = 1'b0;
`endif
        step(v, num, amt, dir, rdy, rot_model(num, int'(amt), dir));
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++)
            step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_o_valid", 32'(bif.o_valid), 32'd0);
        check("rst_o_result", 32'(bif.o_result), 32'd0);
        check("rst_o_ready", 32'(bif.o_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] b1_exp [4];
    logic [2:0]   b1_amt [4];
    logic [N-1:0] walk_exp [8];

    initial begin
        b1_amt   = '{3'd0, 3'd1, 3'd4, 3'd7};
        b1_exp   = '{8'hB1, 8'hD8, 8'h1B, 8'h63};
        walk_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

        bif.i_valid = 1'b0;
        bif.i_num = '0;
        bif.i_num_bit_rotation = '0;
        bif.i_ready = 1'b1;
`ifdef ROT_DIR_SEL_EN
        bif.i_dir = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        check_reset_state();

        // Back-to-back 0xB1 with amounts 0,1,4,7
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'hB1, b1_amt[i], 1'b0, 1'b1, b1_exp[i]);
        drain();

        // Walking one through every amount
        for (int a = 0; a < 8; a++)
            step(1'b1, 8'h01, 3'(a), 1'b0, 1'b1, walk_exp[a]);
        drain();

        // Fill the pipe, then hold the output for three cycles
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b1);
        drain();

        // Alternating valid with downstream always ready
        for (int i = 0; i < 12; i++) rand_step(i % 2 == 0, 1'b1);
        drain();

        // Random valid/ready traffic
        for (int i = 0; i < 300; i++)
            rand_step(($urandom % 4) != 0, ($urandom % 4) != 0);
        drain();

        // Reset with two words in flight: both are discarded
        rand_step(1'b1, 1'b1);
        rand_step(1'b1, 1'b1);
        bif.i_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
        check_reset_state();
        for (int i = 0; i < SW + 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, '0);

`ifdef ROT_DIR_SEL_EN
        step(1'b1, 8'hB1, 3'd1, 1'b1, 1'b1, 8'h63);
        step(1'b1, 8'hB1, 3'd1, 1'b0, 1'b1, 8'hD8);
        for (int i = 0; i < 40; i++) rand_step(1'b1, ($urandom % 3) != 0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rotation_right_shifter_pipe.md
Name: rotation_right_shifter_pipe

Overview:
- Pipelined barrel rotator: rotates an N-bit word right by a runtime amount of 0..N-1, one stage per amount bit.
- Complements the existing combinational left rotator. Used on datapaths that need registered timing and valid/ready flow control.
- One result per cycle when downstream is ready. Latency is fixed at SW cycles.

Parameters:
- N, 8, data width; power of 2, >= 2.
- SW, $clog2(N) (localparam, derived), width of the rotation amount and number of pipeline stages.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  input word and amount are valid.
- o_ready  output  1  block accepts input this cycle.
- i_num  input  N  word to rotate.
- i_num_bit_rotation  input  SW  rotate-right amount, 0..N-1.
- o_valid  output  1  o_result is valid.
- i_ready  input  1  downstream accepts o_result this cycle.
- o_result  output  N  rotated word.

Behaviour:
- Reset, on an edge with i_reset=1:
  - all stage valid bits clear to 0, all stage data/amount registers clear to 0;
  - therefore o_valid=0 and o_result=0 after the edge.
  - o_ready is combinational, so it reads 1 while the pipe is empty.
- Pipeline structure:
  - SW register stages, k = 0..SW-1.
  - Stage k rotates right by 2^k when amount bit k is 1, otherwise passes its data through.
  - Each stage carries data, the remaining amount bits and a valid bit.
- Rotate right by 2^k means result = {d[2^k-1:0], d[N-1:2^k]}. Rotation is purely bit-permuting: no bit is lost or inserted.
- Global advance:
  - adv = !o_valid || i_ready.
  - All stages load from their predecessor only when adv=1; when adv=0 every stage holds.
  - o_ready = adv.
- Acceptance: a transfer occurs on an edge where i_valid && o_ready. On that edge stage 0 loads i_num rotated per amount bit 0.
- Bubbles:
  - When adv=1 and i_valid=0, stage 0 loads valid=0.
  - Bubbles are not collapsed.
- Latency:
  - A word accepted on edge E appears with o_valid=1 after edge E+SW-1, i.e. SW edges counting E. N=8 gives 3 cycles.
  - With i_ready held high, throughput is 1 word per cycle.
- Output hand-off:
  - Downstream takes o_result on an edge where o_valid && i_ready.
  - While o_valid && !i_ready, o_result and o_valid hold stable, and o_ready=0.
- Amount 0: output equals input after SW cycles.
- Amount N-1: equivalent to rotate-left by 1.
- Simultaneous output-take and input-accept on the same edge is legal and required for full throughput.
- Reset mid-operation: all in-flight words are discarded; no partial result is emitted after reset.
- i_num and i_num_bit_rotation are ignored when i_valid=0. X on them is tolerated.

Optional Feature:
- ROT_DIR_SEL_EN defined:
  - Adds input port i_dir (1 bit), sampled with the data and carried down the pipe.
  - i_dir=1: stage k rotates left by 2^k, result = {d[N-1-2^k:0], d[N-1:N-2^k]}.
  - i_dir=0: right rotation as above.
  - Latency, reset and handshake are unchanged.
- ROT_DIR_SEL_EN not defined: no i_dir port; right rotation only.

Test Plan:
- N=8, i_ready=1; send 0xB1 with amounts 0, 1, 4, 7 back-to-back -> o_result 0xB1, 0xD8, 0x1B, 0x63 on 4 consecutive cycles, the first 3 cycles after the first accept.
- Walking-one 0x01 with every amount 0..7 -> o_result = 0x01, 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02.
- Pipe full, i_ready=0 for 3 cycles -> o_ready=0, o_valid=1, o_result stable. After i_ready=1 all words emerge in order with no loss or duplication.
- Alternating i_valid 1/0 with i_ready=1 -> o_valid toggles with identical spacing, 3-cycle latency.
- Two words in flight, i_reset=1 for 1 cycle -> next cycle o_valid=0, o_result=0, o_ready=1; no stale word emitted later.
- ROT_DIR_SEL_EN: 0xB1 with i_dir=1, amount 1 -> 0x63. 0xB1 with i_dir=0, amount 1 -> 0xD8.
